// File: rtl/VX_raster_pkg.sv
// Shared raster types and constants used by the stamp issue path.
package VX_raster_pkg;

    localparam int NUM_THREADS         = 4;
    localparam int NW_WIDTH            = 2;
    localparam int UUID_WIDTH          = 44;
    localparam int RASTER_ISSUE_PERF_W = 32;

    typedef struct packed {
        logic [11:0] pos_x;
        logic [11:0] pos_y;
        logic [7:0]  pid;
    } raster_stamp_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FLUSH = 2'd2,
        RSP   = 2'd3
    } raster_issue_state_e;

    function automatic logic [RASTER_ISSUE_PERF_W-1:0] count_ones(input logic [NUM_THREADS-1:0] v);
        logic [RASTER_ISSUE_PERF_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_THREADS; i++) begin
            n = n + {{(RASTER_ISSUE_PERF_W-1){1'b0}}, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/raster_issue_pid_walk.sv
// PID walker: steps through the warp thread mask one NUM_LANES-wide slice at a time.
module raster_issue_pid_walk
    import VX_raster_pkg::*;
#(
    parameter int NUM_LANES = 1,
    parameter int PID_WIDTH = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   advance,
    input  logic [NUM_THREADS-1:0] tmask,
    output logic [PID_WIDTH-1:0]   pid,
    output logic [NUM_LANES-1:0]   slice,
    output logic                   skip,
    output logic                   last_pid
);

    localparam int NUM_PIDS = NUM_THREADS / NUM_LANES;
    localparam logic [PID_WIDTH-1:0] LAST_PID = PID_WIDTH'(NUM_PIDS - 1);

    logic [PID_WIDTH-1:0] pid_r;

    // PID register; holds at the last slice so it never wraps.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pid_r <= '0;
        end else if (start) begin
            pid_r <= '0;
        end else if (advance && (pid_r != LAST_PID)) begin
            pid_r <= pid_r + PID_WIDTH'(1);
        end else begin
            pid_r <= pid_r;
        end
    end

    // Slice extraction and walk-position decode.
    always_comb begin
        pid      = pid_r;
        slice    = tmask[pid_r*NUM_LANES +: NUM_LANES];
        skip     = (slice == '0);
        last_pid = (pid_r == LAST_PID);
    end

endmodule

// File: rtl/raster_stamp_issue.sv
// Producer side of the per-warp raster CSR write port.
// Optional perf counters are built when RASTER_ISSUE_PERF_EN is defined.
module raster_stamp_issue
    import VX_raster_pkg::*;
#(
    parameter int CORE_ID   = 0,
    parameter int NUM_LANES = 1,
    parameter int PID_WIDTH = ((NUM_THREADS / NUM_LANES) > 1) ? $clog2(NUM_THREADS / NUM_LANES) : 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clear,
    input  logic                           req_valid,
    output logic                           req_ready,
    input  logic [NW_WIDTH-1:0]            req_wid,
    input  logic [NUM_THREADS-1:0]         req_tmask,
    input  logic [UUID_WIDTH-1:0]          req_uuid,
    input  logic                           stamp_valid,
    output logic                           stamp_ready,
    input  raster_stamp_t [NUM_LANES-1:0]  stamp_data,
    input  logic [NUM_LANES-1:0]           stamp_mask,
    input  logic                           stamp_last,
    output logic                           write_enable,
    output logic [UUID_WIDTH-1:0]          write_uuid,
    output logic [NW_WIDTH-1:0]            write_wid,
    output logic [NUM_LANES-1:0]           write_tmask,
    output logic [PID_WIDTH-1:0]           write_pid,
    output raster_stamp_t [NUM_LANES-1:0]  write_data,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [NW_WIDTH-1:0]            rsp_wid,
    output logic [UUID_WIDTH-1:0]          rsp_uuid,
    output logic [NUM_THREADS-1:0]         rsp_tmask,
    output logic                           rsp_done
`ifdef RASTER_ISSUE_PERF_EN
    ,
    output logic [RASTER_ISSUE_PERF_W-1:0] perf_stamps,
    output logic [RASTER_ISSUE_PERF_W-1:0] perf_stalls,
    output logic [RASTER_ISSUE_PERF_W-1:0] perf_idle_warps
`endif
);

    if ((CORE_ID < 0) || ((NUM_THREADS % NUM_LANES) != 0)) begin : g_cfg_err
        $error("raster_stamp_issue: illegal CORE_ID/NUM_LANES configuration");
    end

    raster_issue_state_e state_r, state_s;

    logic [NW_WIDTH-1:0]           wid_r;
    logic [NUM_THREADS-1:0]        tmask_r;
    logic [NUM_THREADS-1:0]        acc_tmask_r;
    logic [UUID_WIDTH-1:0]         uuid_r;
    logic                          exhausted_r;
    logic                          write_enable_r;
    logic [PID_WIDTH-1:0]          write_pid_r;
    logic [NUM_LANES-1:0]          write_tmask_r;
    raster_stamp_t [NUM_LANES-1:0] write_data_r;

    logic [PID_WIDTH-1:0]   pid_s;
    logic [NUM_LANES-1:0]   slice_s;
    logic                   skip_s;
    logic                   last_pid_s;
    logic                   req_fire_s;
    logic                   stamp_fire_s;
    logic                   rsp_fire_s;
    logic                   walk_advance_s;
    logic [NUM_LANES-1:0]   hit_mask_s;
    logic [NUM_THREADS-1:0] hit_thread_s;

    raster_issue_pid_walk #(
        .NUM_LANES (NUM_LANES),
        .PID_WIDTH (PID_WIDTH)
    ) u_pid_walk (
        .clk      (clk),
        .reset    (reset),
        .start    (req_fire_s),
        .advance  (walk_advance_s),
        .tmask    (tmask_r),
        .pid      (pid_s),
        .slice    (slice_s),
        .skip     (skip_s),
        .last_pid (last_pid_s)
    );

    // Handshakes, next state and walk control.
    always_comb begin
        state_s        = state_r;
        walk_advance_s = 1'b0;
        req_ready      = (state_r == IDLE);
        stamp_ready    = (state_r == ISSUE) && !skip_s;
        rsp_valid      = (state_r == RSP);
        req_fire_s     = req_valid && req_ready;
        stamp_fire_s   = stamp_valid && stamp_ready;
        rsp_fire_s     = rsp_valid && rsp_ready;
        hit_mask_s     = slice_s & stamp_mask;
        hit_thread_s   = NUM_THREADS'(hit_mask_s) << (pid_s * NUM_LANES);
        case (state_r)
            IDLE: begin
                if (!req_fire_s) begin
                    state_s = IDLE;
                end else if (exhausted_r || (req_tmask == '0)) begin
                    state_s = FLUSH;
                end else begin
                    state_s = ISSUE;
                end
            end
            ISSUE: begin
                if (skip_s || stamp_fire_s) begin
                    walk_advance_s = 1'b1;
                    if (last_pid_s || (stamp_fire_s && stamp_last)) begin
                        state_s = FLUSH;
                    end else begin
                        state_s = ISSUE;
                    end
                end else begin
                    state_s = ISSUE;
                end
            end
            FLUSH: state_s = RSP;
            RSP: begin
                if (rsp_fire_s) begin
                    state_s = IDLE;
                end else begin
                    state_s = RSP;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Request context and the set of threads that actually got a stamp.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wid_r       <= '0;
            tmask_r     <= '0;
            uuid_r      <= '0;
            acc_tmask_r <= '0;
        end else if (req_fire_s) begin
            wid_r       <= req_wid;
            tmask_r     <= req_tmask;
            uuid_r      <= req_uuid;
            acc_tmask_r <= '0;
        end else if (stamp_fire_s) begin
            acc_tmask_r <= acc_tmask_r | hit_thread_s;
        end else begin
            acc_tmask_r <= acc_tmask_r;
        end
    end

    // Sticky end-of-primitives flag; a coincident clear wins over stamp_last.
    always_ff @(posedge clk) begin
        if (!reset) begin
            exhausted_r <= 1'b0;
        end else if (clear) begin
            exhausted_r <= 1'b0;
        end else if (stamp_fire_s && stamp_last) begin
            exhausted_r <= 1'b1;
        end else begin
            exhausted_r <= exhausted_r;
        end
    end

    // CSR write beat, one cycle after each consumed stamp.
    always_ff @(posedge clk) begin
        if (!reset) begin
            write_enable_r <= 1'b0;
            write_pid_r    <= '0;
            write_tmask_r  <= '0;
            write_data_r   <= '0;
        end else begin
            write_enable_r <= stamp_fire_s;
            if (stamp_fire_s) begin
                write_pid_r   <= pid_s;
                write_tmask_r <= hit_mask_s;
                write_data_r  <= stamp_data;
            end
        end
    end

    assign write_enable = write_enable_r;
    assign write_uuid   = uuid_r;
    assign write_wid    = wid_r;
    assign write_tmask  = write_tmask_r;
    assign write_pid    = write_pid_r;
    assign write_data   = write_data_r;
    assign rsp_wid      = wid_r;
    assign rsp_uuid     = uuid_r;
    assign rsp_tmask    = acc_tmask_r;
    assign rsp_done     = exhausted_r;

`ifdef RASTER_ISSUE_PERF_EN
    logic [RASTER_ISSUE_PERF_W-1:0] perf_stamps_r;
    logic [RASTER_ISSUE_PERF_W-1:0] perf_stalls_r;
    logic [RASTER_ISSUE_PERF_W-1:0] perf_idle_warps_r;

    // Free-running counters, wrapping modulo 2^32.
    always_ff @(posedge clk) begin
        if (!reset) begin
            perf_stamps_r     <= '0;
            perf_stalls_r     <= '0;
            perf_idle_warps_r <= '0;
        end else begin
            if (write_enable_r) begin
                perf_stamps_r <= perf_stamps_r + count_ones(NUM_THREADS'(write_tmask_r));
            end
            if ((state_r == ISSUE) && !skip_s && !stamp_valid) begin
                perf_stalls_r <= perf_stalls_r + 32'd1;
            end
            if (rsp_fire_s && (acc_tmask_r == '0)) begin
                perf_idle_warps_r <= perf_idle_warps_r + 32'd1;
            end
        end
    end

    assign perf_stamps     = perf_stamps_r;
    assign perf_stalls     = perf_stalls_r;
    assign perf_idle_warps = perf_idle_warps_r;
`endif

endmodule

// File: tb/tb_raster_stamp_issue.sv
// Randomized self-checking bench for raster_stamp_issue (NUM_THREADS=4, NUM_LANES=2).
module tb_raster_stamp_issue;
    import VX_raster_pkg::*;

    localparam int L  = 2;
    localparam int NP = NUM_THREADS / L;

    logic                   clk = 1'b0;
    logic                   reset = 1'b0;
    logic                   clear = 1'b0;
    logic                   req_valid = 1'b0;
    logic                   req_ready;
    logic [NW_WIDTH-1:0]    req_wid = '0;
    logic [NUM_THREADS-1:0] req_tmask = '0;
    logic [UUID_WIDTH-1:0]  req_uuid = '0;
    logic                   stamp_valid = 1'b0;
    logic                   stamp_ready;
    logic [63:0]            stamp_data = '0;
    logic [L-1:0]           stamp_mask = '0;
    logic                   stamp_last = 1'b0;
    logic                   write_enable;
    logic [UUID_WIDTH-1:0]  write_uuid;
    logic [NW_WIDTH-1:0]    write_wid;
    logic [L-1:0]           write_tmask;
    logic [0:0]             write_pid;
    logic [63:0]            write_data;
    logic                   rsp_valid;
    logic                   rsp_ready = 1'b0;
    logic [NW_WIDTH-1:0]    rsp_wid;
    logic [UUID_WIDTH-1:0]  rsp_uuid;
    logic [NUM_THREADS-1:0] rsp_tmask;
    logic                   rsp_done;
`ifdef RASTER_ISSUE_PERF_EN
    logic [31:0] perf_stamps, perf_stalls, perf_idle_warps;
`endif

    always #5 clk = ~clk;

    raster_stamp_issue #(.CORE_ID(0), .NUM_LANES(L), .PID_WIDTH(1)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready), .req_wid(req_wid),
        .req_tmask(req_tmask), .req_uuid(req_uuid),
        .stamp_valid(stamp_valid), .stamp_ready(stamp_ready), .stamp_data(stamp_data),
        .stamp_mask(stamp_mask), .stamp_last(stamp_last),
        .write_enable(write_enable), .write_uuid(write_uuid), .write_wid(write_wid),
        .write_tmask(write_tmask), .write_pid(write_pid), .write_data(write_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_wid(rsp_wid),
        .rsp_uuid(rsp_uuid), .rsp_tmask(rsp_tmask), .rsp_done(rsp_done)
`ifdef RASTER_ISSUE_PERF_EN
        , .perf_stamps(perf_stamps), .perf_stalls(perf_stalls), .perf_idle_warps(perf_idle_warps)
`endif
    );

    typedef struct {
        int                    cyc;
        logic [0:0]            pid;
        logic [L-1:0]          tm;
        logic [63:0]           data;
        logic [NW_WIDTH-1:0]   wid;
        logic [UUID_WIDTH-1:0] uuid;
    } wr_t;

    wr_t         exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          m_exh = 1'b0;
    int unsigned m_stamps = 0;
    int unsigned m_stalls = 0;
    int unsigned m_idle = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Every write beat must match the next expected beat, in order and on the expected cycle.
    always @(negedge clk) begin
        if (write_enable) begin
            if (exp_q.size() == 0) begin
                chk("wr_spurious", 64'd1, 64'd0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_cyc", 64'(cyc), 64'(e.cyc));
                chk("wr_pid", 64'(write_pid), 64'(e.pid));
                chk("wr_tmask", 64'(write_tmask), 64'(e.tm));
                chk("wr_data", write_data, e.data);
                chk("wr_wid", 64'(write_wid), 64'(e.wid));
                chk("wr_uuid", 64'(write_uuid), 64'(e.uuid));
            end
        end
    end

    task automatic drive_idle();
        req_valid   = 1'b0;
        stamp_valid = 1'b0;
        stamp_last  = 1'b0;
        clear       = 1'b0;
        rsp_ready   = 1'b0;
    endtask

    task automatic perf_check();
`ifdef RASTER_ISSUE_PERF_EN
        chk("perf_stamps", 64'(perf_stamps), 64'(m_stamps));
        chk("perf_stalls", 64'(perf_stalls), 64'(m_stalls));
        chk("perf_idle_warps", 64'(perf_idle_warps), 64'(m_idle));
`endif
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        drive_idle();
        clear = 1'b1;
        m_exh = 1'b0;
        @(negedge clk);
        clear = 1'b0;
    endtask

    // One warp request end to end; the model walks PID slices by the rules, not by DUT state.
    task automatic run_txn(input logic [NW_WIDTH-1:0] wid, input logic [3:0] tm, input bit rnd,
                           input logic [L-1:0] fmask, input bit last_first, input int stall, input int hold);
        logic [UUID_WIDTH-1:0] uuid;
        logic [3:0]            acc;
        logic [L-1:0]          sl, msk;
        logic [63:0]           dat;
        bit                    v, lst, clr, fire, fired;
        int                    phase, pid, nb;
        uuid = UUID_WIDTH'({$urandom(), $urandom()});
        @(negedge clk);
        drive_idle();
        perf_check();
        chk("req_ready_idle", 64'(req_ready), 64'd1);
        req_valid   = 1'b1;
        req_wid     = wid;
        req_tmask   = tm;
        req_uuid    = uuid;
        stamp_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        phase = (m_exh || tm == 4'd0) ? 1 : 0;
        pid = 0; nb = 0; acc = 4'd0; fired = 1'b0;
        for (int c = 0; c < 200 && !fired; c++) begin
            @(negedge clk);
            req_valid = 1'b0;
            sl  = tm[pid*L +: L];
            clr = rnd && ($urandom_range(0, 15) == 0);
            msk = rnd ? L'($urandom_range(0, 3)) : fmask;
            dat = {$urandom(), $urandom()};
            lst = rnd ? ($urandom_range(0, 5) == 0) : (last_first && nb == 0);
            if (phase == 0 && sl != 0 && nb == 1 && stall > 0) begin
                v = 1'b0;
                stall--;
            end else begin
                v = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            end
            clear = clr; stamp_valid = v; stamp_data = dat; stamp_mask = msk; stamp_last = lst;
            rsp_ready = 1'b0;
            if (phase == 2) begin
                if (hold < 0) rsp_ready = ($urandom_range(0, 2) == 0);
                else if (hold > 0) hold--;
                else rsp_ready = 1'b1;
            end
            chk("stamp_ready", 64'(stamp_ready), 64'(phase == 0 && sl != 0));
            chk("rsp_valid", 64'(rsp_valid), 64'(phase == 2));
            chk("req_ready_busy", 64'(req_ready), 64'd0);
            if (phase == 2) begin
                chk("rsp_wid", 64'(rsp_wid), 64'(wid));
                chk("rsp_uuid", 64'(rsp_uuid), 64'(uuid));
                chk("rsp_tmask", 64'(rsp_tmask), 64'(acc));
                chk("rsp_done", 64'(rsp_done), 64'(m_exh));
            end
            fire = (phase == 0) && (sl != 0) && v;
            if (phase == 0) begin
                if (sl == 0 || v) begin
                    if (fire) begin
                        exp_q.push_back('{cyc + 1, 1'(pid), sl & msk, dat, wid, uuid});
                        acc = acc | (4'(sl & msk) << (pid * L));
                        m_stamps += $countones(sl & msk);
                        nb++;
                    end
                    if (pid == NP - 1 || (fire && lst)) phase = 1;
                    else pid++;
                end else begin
                    m_stalls++;
                end
            end else if (phase == 1) begin
                phase = 2;
            end else if (rsp_ready) begin
                fired = 1'b1;
                if (acc == 4'd0) m_idle++;
            end
            if (clr) m_exh = 1'b0;
            else if (fire && lst) m_exh = 1'b1;
        end
        if (!fired) begin
            chk("rsp_timeout", 64'd0, 64'd1);
            $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
            $finish;
        end
        @(posedge clk);
    endtask

    // Reset pulse right after the pid0 write of a full warp.
    task automatic reset_mid();
        logic [63:0]           dat;
        logic [UUID_WIDTH-1:0] uuid;
        dat  = {$urandom(), $urandom()};
        uuid = UUID_WIDTH'({$urandom(), $urandom()});
        @(negedge clk);
        drive_idle();
        req_valid = 1'b1; req_wid = 2'd1; req_tmask = 4'b1111; req_uuid = uuid;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_pre_ready", 64'(stamp_ready), 64'd1);
        stamp_valid = 1'b1; stamp_mask = 2'b11; stamp_last = 1'b0; stamp_data = dat;
        exp_q.push_back('{cyc + 1, 1'b0, 2'b11, dat, 2'd1, uuid});
        @(negedge clk);
        stamp_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_exh = 1'b0; m_stamps = 0; m_stalls = 0; m_idle = 0;
        chk("rst_wr_en", 64'(write_enable), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd1);
        chk("rst_stamp_ready", 64'(stamp_ready), 64'd0);
        stamp_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("rst_after_rsp_valid", 64'(rsp_valid), 64'd0);
            chk("rst_after_stamp_ready", 64'(stamp_ready), 64'd0);
        end
        stamp_valid = 1'b0;
    endtask

    initial begin
        drive_idle();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_stamp_ready", 64'(stamp_ready), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_wr_en", 64'(write_enable), 64'd0);
        chk("reset_rsp_done", 64'(rsp_done), 64'd0);
        reset = 1'b1;

        run_txn(2'd3, 4'b1111, 1'b0, 2'b11, 1'b0, 0, 0);   // full warp
        run_txn(2'd2, 4'b1100, 1'b0, 2'b01, 1'b0, 0, 0);   // skipped slice
        run_txn(2'd0, 4'b1111, 1'b0, 2'b10, 1'b1, 0, 0);   // stamp_last on first beat
        run_txn(2'd1, 4'b1111, 1'b0, 2'b11, 1'b0, 0, 1);   // exhausted: flush only
        pulse_clear();
        run_txn(2'd1, 4'b0110, 1'b0, 2'b11, 1'b0, 0, 0);   // normal after clear
        run_txn(2'd2, 4'b1111, 1'b0, 2'b11, 1'b0, 5, 3);   // back-pressure
        run_txn(2'd0, 4'b0000, 1'b0, 2'b11, 1'b0, 0, 0);   // zero mask
        reset_mid();
        run_txn(2'd3, 4'b1011, 1'b0, 2'b11, 1'b0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            if ($urandom_range(0, 3) == 0) pulse_clear();
            run_txn(NW_WIDTH'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 1'b1, 2'b00, 1'b0, 0, -1);
        end

        @(negedge clk);
        drive_idle();
        perf_check();
        repeat (3) @(negedge clk);
        chk("wr_pending", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
